uart_rx_fifo: RTL and testbench
===============================

# uart_rx_fifo

Serial receiver for the CPU's UART port: samples the asynchronous `rxd` pin, deframes 8N1 characters, and buffers received bytes in a small FIFO. Bytes are presented to the CPU-side load/store logic over a valid/ready interface. It is the receive counterpart to the CPU's `txd` transmitter. It runs in the 50 MHz CPU clock domain.

## Interface
- `CLK_FREQ`, 50_000_000: clock frequency in Hz.
- `BAUD`, 115200: line rate in bits per second.
- `FIFO_DEPTH`, 4: byte entries. Must be a power of 2 and at least 2.
- Derived: `DIV` = round(CLK_FREQ/BAUD), which is 434 with the defaults. `HALF` = DIV/2 (integer division), which is 217.
- `cpu_clk`  in  1  CPU clock. Only clock in the block.
- `cpu_rst`  in  1  Reset. Synchronous, active-high.
- `rxd`  in  1  Serial input, asynchronous. Idles high.
- `rx_data`  out  8  FIFO head byte. Valid only while `rx_valid` is high.
- `rx_valid`  out  1  FIFO not empty.
- `rx_ready`  in  1  Consumer accepts the head. A pop occurs on a cycle where `rx_valid && rx_ready`.
- `err_clr`  in  1  One-cycle pulse that clears both sticky error flags.
- `rx_overrun`  out  1  Sticky. A byte was dropped because the FIFO was full.
- `frame_err`  out  1  Sticky. A stop bit was sampled low.

## Operation
- Input synchronizer:
  - `rxd` passes through 2 flops, both reset to 1. The FSM sees only the synchronized value `rxs`.
- Baud counter:
  - 16-bit down-counter `cnt`. A "tick" is a cycle where `cnt == 0`; on a tick, `cnt` reloads per state.
- FSM states: IDLE, START, DATA, STOP, WAIT_IDLE. Reset state is IDLE.
- IDLE:
  - If `rxs == 0`: load `cnt = HALF-1` and go to START.
- START: on tick, sample `rxs`.
  - If 1: false start, return to IDLE.
  - If 0: load `cnt = DIV-1`, clear the bit index, go to DATA.
- DATA: on each tick, shift `rxs` in LSB-first and load `cnt = DIV-1`.
  - After the 8th bit, go to STOP.
- STOP: on tick, sample `rxs`.
  - If 1: push the byte, go to IDLE.
  - If 0: set `frame_err`, drop the byte, go to WAIT_IDLE.
- WAIT_IDLE:
  - Stay until `rxs == 1`, then go to IDLE. This prevents a break condition from retriggering reception.
- FIFO:
  - Circular buffer with read/write pointers of log2(FIFO_DEPTH) bits and a count of log2(FIFO_DEPTH)+1 bits. Pointers wrap modulo FIFO_DEPTH.
  - `rx_data` is the entry at the read pointer (combinational read).
- Push when full:
  - Accepted if a pop occurs in the same cycle.
  - Otherwise the byte is dropped, `rx_overrun` is set, and FIFO contents are unchanged.
- Push and pop in the same cycle when the FIFO is not full: count is unchanged and both pointers advance.
- Pop while empty cannot occur, because `rx_valid` is low.
- Error flags:
  - `err_clr` clears both flags.
  - If a set event and `err_clr` occur in the same cycle, the set wins.
- Reset:
  - `cpu_rst` at any point, including mid-frame, returns the FSM to IDLE and empties the FIFO.
  - It also clears both flags and sets the synchronizer to 1. The partial byte is discarded.
- Reset values: `rx_valid` = 0, `rx_overrun` = 0, `frame_err` = 0. `rx_data` is undefined (don't care) while `rx_valid` = 0.

## Timing
- Synchronizer latency: 2 cycles from the `rxd` edge to `rxs`.
- Stop-bit sample: HALF + 9*DIV cycles after IDLE first sees `rxs == 0`. With defaults that is 217 + 3906 = 4123 cycles.
- `rx_valid` rises the cycle after the stop-bit sample. Pin-to-valid latency with defaults is 4126 cycles.
- Pop semantics: the read pointer advances at the clock edge where `rx_valid && rx_ready`. The next entry (or `rx_valid` = 0) appears in the following cycle.
- Back-to-back frames: IDLE is re-entered at the stop-bit midpoint, so a start bit that follows immediately is detected. No gap is needed.
- Sampling error tolerance: about ±4% total baud mismatch. Beyond that, behaviour is undefined.

## Test plan
- Reset values: assert `cpu_rst` for 3 cycles with `rxd` = 1 → `rx_valid` = 0, `rx_overrun` = 0, `frame_err` = 0. No activity for 10000 cycles.
- Single byte: drive 0x55 at 434 cycles/bit → `rx_valid` = 1 with `rx_data` = 0x55 exactly 4126 cycles after the start edge. With `rx_ready` = 1 for one cycle, `rx_valid` = 0 the next cycle.
- False start: pull `rxd` low for 100 cycles, then hold high → no push, FSM back in IDLE, a later 0xA3 frame is received as 0xA3.
- Framing error: send 0x0F with the stop bit low, then hold low for 2000 cycles, then high → `frame_err` = 1, FIFO empty, no retrigger. A following 0x3C is received correctly. `err_clr` clears `frame_err`.
- Overrun: send 5 bytes 0x01–0x05 with `rx_ready` = 0 → 4 entries (0x01–0x04) read out in order, `rx_overrun` = 1.
- Full push plus pop, and reset mid-frame:
  - With the FIFO full, time `rx_ready` to pop on the 5th byte's push cycle → no overrun, and the read order is 0x02–0x05.
  - Assert `cpu_rst` in the middle of bit 4 → empty FIFO. The next frame decodes correctly.

Source files
------------

// File: rtl/uart_rx_fifo.sv
// 8N1 UART receiver for the CPU rxd pin: 2-flop synchronizer, mid-bit sampling
// deframer and a small byte FIFO presented over a valid/ready interface.
module uart_rx_fifo #(
    parameter int CLK_FREQ   = 50_000_000,
    parameter int BAUD       = 115200,
    parameter int FIFO_DEPTH = 4
) (
    input  logic       cpu_clk,
    input  logic       cpu_rst,
    input  logic       rxd,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    input  logic       rx_ready,
    input  logic       err_clr,
    output logic       rx_overrun,
    output logic       frame_err
);
    localparam int DIV   = (CLK_FREQ + BAUD / 2) / BAUD;
    localparam int HALF  = DIV / 2;
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam logic [15:0]    DIV_M1  = 16'(DIV - 1);
    localparam logic [15:0]    HALF_M1 = 16'(HALF - 1);
    localparam logic [PTR_W:0] FULL_CNT = (PTR_W + 1)'(FIFO_DEPTH);

    typedef enum logic [2:0] {IDLE, START, DATA, STOP, WAIT_IDLE} state_t;

    state_t           state, state_nxt;
    logic             rxd_p0, rxd_p1, rxs;
    logic [15:0]      cnt;
    logic             tick;
    logic [2:0]       bit_idx;
    logic [7:0]       shreg;
    logic             load_half, load_div, shift_en, bit_clr, push_req, ferr_set;
    logic [7:0]       mem [FIFO_DEPTH];
    logic [PTR_W-1:0] wptr, rptr;
    logic [PTR_W:0]   count;
    logic             full, pop, push_ok, drop;

    // Stage p0/p1: metastability synchronizer, idles high
    always_ff @(posedge cpu_clk) begin
        if (cpu_rst) begin
            rxd_p0 <= 1'b1;
            rxd_p1 <= 1'b1;
        end else begin
            rxd_p0 <= rxd;
            rxd_p1 <= rxd_p0;
        end
    end
    assign rxs  = rxd_p1;
    assign tick = (cnt == 16'd0);

    // Deframer FSM
    always_ff @(posedge cpu_clk) begin
        if (cpu_rst) state <= IDLE;
        else         state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:      if (!rxs) state_nxt = START;
            START:     if (tick) state_nxt = rxs ? IDLE : DATA;
            DATA:      if (tick && bit_idx == 3'd7) state_nxt = STOP;
            STOP:      if (tick) state_nxt = rxs ? IDLE : WAIT_IDLE;
            WAIT_IDLE: if (rxs) state_nxt = IDLE;
            default:   state_nxt = IDLE;
        endcase
    end

    always_comb begin
        load_half = 1'b0;
        load_div  = 1'b0;
        shift_en  = 1'b0;
        bit_clr   = 1'b0;
        push_req  = 1'b0;
        ferr_set  = 1'b0;
        case (state)
            IDLE:  load_half = !rxs;
            START: begin
                load_div = tick && !rxs;
                bit_clr  = tick && !rxs;
            end
            DATA: begin
                shift_en = tick;
                load_div = tick;
            end
            STOP: begin
                push_req = tick && rxs;
                ferr_set = tick && !rxs;
            end
            default: ;
        endcase
    end

    always_ff @(posedge cpu_clk) begin
        if (cpu_rst) begin
            cnt     <= 16'd0;
            bit_idx <= 3'd0;
        end else begin
            if (load_half)     cnt <= HALF_M1;
            else if (load_div) cnt <= DIV_M1;
            else if (!tick)    cnt <= cnt - 16'd1;
            if (bit_clr)       bit_idx <= 3'd0;
            else if (shift_en) bit_idx <= bit_idx + 3'd1;
        end
    end

    always_ff @(posedge cpu_clk) begin
        if (shift_en) shreg <= {rxs, shreg[7:1]};
    end

    // A full FIFO still takes a byte when the head leaves on the same edge
    assign full    = (count == FULL_CNT);
    assign pop     = rx_valid && rx_ready;
    assign push_ok = push_req && (!full || pop);
    assign drop    = push_req && full && !pop;

    always_ff @(posedge cpu_clk) begin
        if (push_ok) mem[wptr] <= shreg;
    end

    always_ff @(posedge cpu_clk) begin
        if (cpu_rst) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else begin
            if (push_ok) wptr <= wptr + PTR_W'(1);
            if (pop)     rptr <= rptr + PTR_W'(1);
            case ({push_ok, pop})
                2'b10:   count <= count + (PTR_W + 1)'(1);
                2'b01:   count <= count - (PTR_W + 1)'(1);
                default: count <= count;
            endcase
        end
    end

    assign rx_valid = (count != '0);
    assign rx_data  = mem[rptr];

    // Sticky flags: a new event beats a simultaneous clear
    always_ff @(posedge cpu_clk) begin
        if (cpu_rst) begin
            rx_overrun <= 1'b0;
            frame_err  <= 1'b0;
        end else begin
            if (drop)         rx_overrun <= 1'b1;
            else if (err_clr) rx_overrun <= 1'b0;
            if (ferr_set)     frame_err  <= 1'b1;
            else if (err_clr) frame_err  <= 1'b0;
        end
    end

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Directed bench for uart_rx_fifo at default parameters (434 clocks per bit).
module tb_uart_rx_fifo;
    localparam int DIV = 434;

    logic       cpu_clk = 1'b0;
    logic       cpu_rst, rxd, rx_ready, err_clr;
    logic [7:0] rx_data;
    logic       rx_valid, rx_overrun, frame_err;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [7:0] data;
        logic       stop;
        int         hold;
        int         settle;
        logic       exp_valid;
        logic [7:0] exp_data;
        logic       exp_ferr;
    } vec_t;

    vec_t vecs [3];

    uart_rx_fifo dut (
        .cpu_clk    (cpu_clk),
        .cpu_rst    (cpu_rst),
        .rxd        (rxd),
        .rx_data    (rx_data),
        .rx_valid   (rx_valid),
        .rx_ready   (rx_ready),
        .err_clr    (err_clr),
        .rx_overrun (rx_overrun),
        .frame_err  (frame_err)
    );

    always #5 cpu_clk = ~cpu_clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge cpu_clk);
        #1;
    endtask

    task automatic drive_bit(input logic v);
        rxd = v;
        step(DIV);
    endtask

    task automatic send_frame(input logic [7:0] d, input logic stop);
        drive_bit(1'b0);
        for (int i = 0; i < 8; i++) drive_bit(d[i]);
        drive_bit(stop);
    endtask

    task automatic pop_one();
        rx_ready = 1'b1;
        step(1);
        rx_ready = 1'b0;
    endtask

    task automatic pulse_clr();
        err_clr = 1'b1;
        step(1);
        err_clr = 1'b0;
    endtask

    initial begin
        int saw;
        logic [7:0] partial;

        vecs[0] = '{data: 8'hA3, stop: 1'b1, hold: 0,    settle: 0,    exp_valid: 1'b1, exp_data: 8'hA3, exp_ferr: 1'b0};
        vecs[1] = '{data: 8'h0F, stop: 1'b0, hold: 2000, settle: 1000, exp_valid: 1'b0, exp_data: 8'h00, exp_ferr: 1'b1};
        vecs[2] = '{data: 8'h3C, stop: 1'b1, hold: 0,    settle: 0,    exp_valid: 1'b1, exp_data: 8'h3C, exp_ferr: 1'b1};

        cpu_rst  = 1'b1;
        rxd      = 1'b1;
        rx_ready = 1'b0;
        err_clr  = 1'b0;
        step(3);
        cpu_rst = 1'b0;
        check("reset_valid", rx_valid, 0);
        check("reset_overrun", rx_overrun, 0);
        check("reset_frame_err", frame_err, 0);

        saw = 0;
        repeat (10000) begin
            step(1);
            if (rx_valid || rx_overrun || frame_err) saw = 1;
        end
        check("idle_quiet", saw, 0);

        // Pin-to-valid latency: low after 4125 edges, high after 4126
        fork
            send_frame(8'h55, 1'b1);
            begin
                step(4125);
                check("latency_not_yet", rx_valid, 0);
                step(1);
                check("latency_valid", rx_valid, 1);
                check("latency_data", rx_data, 8'h55);
            end
        join
        pop_one();
        check("single_popped", rx_valid, 0);

        rxd = 1'b0;
        step(100);
        rxd = 1'b1;
        step(500);
        check("false_start_valid", rx_valid, 0);
        check("false_start_ferr", frame_err, 0);

        for (int i = 0; i < 3; i++) begin
            send_frame(vecs[i].data, vecs[i].stop);
            step(vecs[i].hold);
            rxd = 1'b1;
            step(vecs[i].settle);
            check($sformatf("vec%0d_valid", i), rx_valid, vecs[i].exp_valid);
            check($sformatf("vec%0d_ferr", i), frame_err, vecs[i].exp_ferr);
            if (vecs[i].exp_valid) begin
                check($sformatf("vec%0d_data", i), rx_data, vecs[i].exp_data);
                pop_one();
                check($sformatf("vec%0d_popped", i), rx_valid, 0);
            end
        end
        pulse_clr();
        check("ferr_cleared", frame_err, 0);

        for (int b = 1; b <= 5; b++) send_frame(8'(b), 1'b1);
        check("overrun_set", rx_overrun, 1);
        for (int b = 1; b <= 4; b++) begin
            check($sformatf("overrun_valid%0d", b), rx_valid, 1);
            check($sformatf("overrun_data%0d", b), rx_data, 8'(b));
            pop_one();
        end
        check("overrun_drained", rx_valid, 0);
        pulse_clr();
        check("overrun_cleared", rx_overrun, 0);

        // Full FIFO with a pop on the same edge as the 5th push
        for (int b = 1; b <= 4; b++) send_frame(8'(b), 1'b1);
        check("full_no_overrun", rx_overrun, 0);
        fork
            send_frame(8'h05, 1'b1);
            begin
                step(4125);
                rx_ready = 1'b1;
                step(1);
                rx_ready = 1'b0;
            end
        join
        check("pushpop_no_overrun", rx_overrun, 0);
        for (int b = 2; b <= 4; b++) begin
            check($sformatf("pushpop_data%0d", b), rx_data, 8'(b));
            pop_one();
        end
        check("pushpop_last_valid", rx_valid, 1);
        check("pushpop_last_data", rx_data, 8'h05);

        // Reset in the middle of data bit 4 with one byte still queued
        partial = 8'h5A;
        drive_bit(1'b0);
        for (int i = 0; i < 4; i++) drive_bit(partial[i]);
        rxd = partial[4];
        step(DIV / 2);
        cpu_rst = 1'b1;
        step(3);
        cpu_rst = 1'b0;
        rxd = 1'b1;
        check("midreset_valid", rx_valid, 0);
        check("midreset_overrun", rx_overrun, 0);
        check("midreset_ferr", frame_err, 0);
        step(100);
        send_frame(8'hC6, 1'b1);
        check("after_reset_valid", rx_valid, 1);
        check("after_reset_data", rx_data, 8'hC6);
        pop_one();
        check("after_reset_popped", rx_valid, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
